// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU between the register file and writeback.
//
// One operation is accepted per start (when idle). Single-cycle operations
// complete on the accepting edge. MUL (shift-add) and DIV (restoring) take
// WIDTH further cycles. done pulses for one cycle when result and flags are
// valid. Outputs hold their values until the next completion or reset.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   start        request, accepted when busy=0
//   op           6-bit opcode, sampled at acceptance
//   a, b         operands, sampled at acceptance
//   result       primary result
//   result_hi    MUL upper product half / DIV remainder / 0
//   busy         iterative operation in progress
//   done         one-cycle completion pulse
//   zero         result==0
//   carry        ADD carry-out / SUB borrow
//   overflow     ADD/SUB signed overflow, MUL upper half non-zero
//   div_by_zero  DIV with b==0
//   illegal_op   unrecognised opcode
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal_op
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_MUL = 6'b000010;
   localparam logic [5:0] OP_DIV = 6'b000011;
   localparam logic [5:0] OP_CMP = 6'b000100;
   localparam logic [5:0] OP_NOT = 6'b001000;
   localparam logic [5:0] OP_AND = 6'b001001;
   localparam logic [5:0] OP_OR  = 6'b001010;
   localparam logic [5:0] OP_XOR = 6'b001011;
   localparam logic [5:0] OP_SHL = 6'b010000;
   localparam logic [5:0] OP_SHR = 6'b010001;
   localparam logic [5:0] OP_SAR = 6'b010010;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   // Everything that is registered together at a completing edge.
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [WIDTH-1:0] result_hi;
      logic             zero;
      logic             carry;
      logic             overflow;
      logic             div_by_zero;
      logic             illegal_op;
   } out_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd;    // multiplicand (MUL) or divisor (DIV)
   logic [WIDTH-1:0] acc_hi;  // MUL: running upper product half
   logic [WIDTH-1:0] acc_lo;  // MUL: multiplier/low product; DIV: dividend/quotient
   logic [WIDTH-1:0] rem;     // DIV: partial remainder (always < divisor)
   out_t             out_q;

   // ---------------- single-cycle datapath ----------------
   out_t             sc_out;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [SHW-1:0]   shamt;

   // NOTE: every signal written in always_comb is given a default first so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      sc_out   = '0;
      add_full = {1'b0, a} + {1'b0, b};
      sub_full = {1'b0, a} - {1'b0, b};
      shamt    = b[SHW-1:0];
      case (op)
         OP_ADD: begin
            sc_out.result   = add_full[WIDTH-1:0];
            sc_out.carry    = add_full[WIDTH];
            sc_out.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                              (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_out.result   = sub_full[WIDTH-1:0];
            sc_out.carry    = sub_full[WIDTH];  // borrow: a < b unsigned
            sc_out.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                              (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: begin
            // Always iterative; nothing to produce here.
         end
         OP_DIV: begin
            // Only used when b==0; non-zero divisors iterate.
            sc_out.result      = '1;
            sc_out.result_hi   = a;
            sc_out.div_by_zero = 1'b1;
         end
         OP_CMP: begin
            if (a > b)      sc_out.result[1:0] = 2'b01;
            else if (a < b) sc_out.result[1:0] = 2'b10;
         end
         OP_NOT: sc_out.result = ~a;
         OP_AND: sc_out.result = a & b;
         OP_OR:  sc_out.result = a | b;
         OP_XOR: sc_out.result = a ^ b;
         // Shift amounts >= WIDTH naturally give 0 (or all sign bits for SAR).
         OP_SHL: sc_out.result = a << shamt;
         OP_SHR: sc_out.result = a >> shamt;
         OP_SAR: sc_out.result = $unsigned($signed(a) >>> shamt);
         default: sc_out.illegal_op = 1'b1;
      endcase
      sc_out.zero = (sc_out.result == '0) && !sc_out.illegal_op;
   end

   // ---------------- MUL iteration (shift-add, LSB first) ----------------
   out_t             mul_out;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nxt;
   logic [WIDTH-1:0] mul_lo_nxt;

   always_comb begin
      mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      mul_hi_nxt = mul_sum[WIDTH:1];
      mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      mul_out           = '0;
      mul_out.result    = mul_lo_nxt;
      mul_out.result_hi = mul_hi_nxt;
      mul_out.zero      = (mul_lo_nxt == '0);
      mul_out.overflow  = (mul_hi_nxt != '0);
   end

   // ---------------- DIV iteration (restoring, MSB first) ----------------
   out_t             div_out;
   logic [WIDTH:0]   div_shift;  // WIDTH+1-bit partial remainder
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   always_comb begin
      div_shift = {rem, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      // div_shift < 2*divisor, so the subtraction succeeds when the shifted
      // value reaches 2^WIDTH or the difference does not wrap negative.
      div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
      rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_nxt   = {acc_lo[WIDTH-2:0], div_ge};
      div_out           = '0;
      div_out.result    = quo_nxt;
      div_out.result_hi = rem_nxt;
      div_out.zero      = (quo_nxt == '0);
   end

   // ---------------- control and state ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are cleared too; they feed nothing
         // visible until reloaded, but a fully known state eases debug.
         state  <= S_IDLE;
         cnt    <= '0;
         opnd   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         rem    <= '0;
         out_q  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (op == OP_MUL) begin
                     opnd   <= a;
                     acc_hi <= '0;
                     acc_lo <= b;
                     cnt    <= '0;
                     state  <= S_MUL;
                  end else if (op == OP_DIV && b != '0) begin
                     opnd   <= b;
                     rem    <= '0;
                     acc_lo <= a;
                     cnt    <= '0;
                     state  <= S_DIV;
                  end else begin
                     out_q <= sc_out;
                     done  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_hi <= mul_hi_nxt;
               acc_lo <= mul_lo_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  out_q <= mul_out;
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            end
            S_DIV: begin
               rem    <= rem_nxt;
               acc_lo <= quo_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  out_q <= div_out;
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state != S_IDLE);
   assign result      = out_q.result;
   assign result_hi   = out_q.result_hi;
   assign zero        = out_q.zero;
   assign carry       = out_q.carry;
   assign overflow    = out_q.overflow;
   assign div_by_zero = out_q.div_by_zero;
   assign illegal_op  = out_q.illegal_op;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8 and WIDTH=16.
// Flags are compared as {zero, carry, overflow, div_by_zero, illegal_op}.
module tb_alu_seq;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_MUL = 6'b000010;
   localparam logic [5:0] OP_DIV = 6'b000011;
   localparam logic [5:0] OP_CMP = 6'b000100;
   localparam logic [5:0] OP_NOT = 6'b001000;
   localparam logic [5:0] OP_AND = 6'b001001;
   localparam logic [5:0] OP_OR  = 6'b001010;
   localparam logic [5:0] OP_XOR = 6'b001011;
   localparam logic [5:0] OP_SHL = 6'b010000;
   localparam logic [5:0] OP_SHR = 6'b010001;
   localparam logic [5:0] OP_SAR = 6'b010010;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start8, busy8, done8, zero8, carry8, ovf8, dbz8, ill8;
   logic [5:0]  op8;
   logic [7:0]  a8, b8, res8, hi8;

   logic        start16, busy16, done16, zero16, carry16, ovf16, dbz16, ill16;
   logic [5:0]  op16;
   logic [15:0] a16, b16, res16, hi16;

   alu_seq #(.WIDTH(8)) u_alu8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .result(res8), .result_hi(hi8), .busy(busy8), .done(done8),
      .zero(zero8), .carry(carry8), .overflow(ovf8),
      .div_by_zero(dbz8), .illegal_op(ill8)
   );

   alu_seq #(.WIDTH(16)) u_alu16 (
      .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
      .result(res16), .result_hi(hi16), .busy(busy16), .done(done16),
      .zero(zero16), .carry(carry16), .overflow(ovf16),
      .div_by_zero(dbz16), .illegal_op(ill16)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op on the 8-bit DUT; return cycles from acceptance to done.
   task automatic run8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int cyc);
      @(negedge clk);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run16(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int cyc);
      @(negedge clk);
      start16 = 1'b1; op16 = op; a16 = a; b16 = b;
      @(negedge clk);
      start16 = 1'b0;
      cyc = 0;
      while (!done16 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic exp8(input string tag, input int cyc, input int exp_cyc,
                       input logic [7:0] r, input logic [7:0] h, input logic [4:0] f);
      check({tag, "_lat"},   cyc, exp_cyc);
      check({tag, "_res"},   res8, r);
      check({tag, "_hi"},    hi8, h);
      check({tag, "_flags"}, {zero8, carry8, ovf8, dbz8, ill8}, f);
   endtask

   task automatic exp16(input string tag, input int cyc, input int exp_cyc,
                        input logic [15:0] r, input logic [15:0] h, input logic [4:0] f);
      check({tag, "_lat"},   cyc, exp_cyc);
      check({tag, "_res"},   res16, r);
      check({tag, "_hi"},    hi16, h);
      check({tag, "_flags"}, {zero16, carry16, ovf16, dbz16, ill16}, f);
   endtask

   initial begin
      int cyc;
      int pulses;

      rst = 1'b1;
      start8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_res",  {res8, hi8}, 16'h0000);
      check("rst_flags", {zero8, carry8, ovf8, dbz8, ill8}, 5'b00000);
      rst = 1'b0;

      // Arithmetic and compare
      run8(OP_ADD, 8'hF0, 8'h20, cyc); exp8("add_carry", cyc, 0, 8'h10, 8'h00, 5'b01000);
      run8(OP_ADD, 8'h7F, 8'h01, cyc); exp8("add_ovf",   cyc, 0, 8'h80, 8'h00, 5'b00100);
      run8(OP_SUB, 8'd5,  8'd7,  cyc); exp8("sub_borrow", cyc, 0, 8'hFE, 8'h00, 5'b01000);
      run8(OP_CMP, 8'd5,  8'd7,  cyc); exp8("cmp_lt",    cyc, 0, 8'h02, 8'h00, 5'b00000);
      run8(OP_CMP, 8'd9,  8'd5,  cyc); exp8("cmp_gt",    cyc, 0, 8'h01, 8'h00, 5'b00000);
      run8(OP_CMP, 8'd9,  8'd9,  cyc); exp8("cmp_eq",    cyc, 0, 8'h00, 8'h00, 5'b10000);

      // Outputs hold between done pulses
      @(negedge clk);
      check("hold_done", done8, 1'b0);
      check("hold_zero", zero8, 1'b1);

      // Logic ops
      run8(OP_NOT, 8'h96, 8'h0F, cyc); exp8("not", cyc, 0, 8'h69, 8'h00, 5'b00000);
      run8(OP_AND, 8'h96, 8'h0F, cyc); exp8("and", cyc, 0, 8'h06, 8'h00, 5'b00000);
      run8(OP_OR,  8'h96, 8'h0F, cyc); exp8("or",  cyc, 0, 8'h9F, 8'h00, 5'b00000);
      run8(OP_XOR, 8'h96, 8'h0F, cyc); exp8("xor", cyc, 0, 8'h99, 8'h00, 5'b00000);

      // MUL with a start pulse mid-operation that must be dropped
      @(negedge clk);
      start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      check("mul_busy", busy8, 1'b1);
      cyc = 0;
      repeat (3) begin @(negedge clk); cyc++; end
      start8 = 1'b1; op8 = OP_ADD; a8 = 8'd1; b8 = 8'd1;
      @(negedge clk); cyc++;
      start8 = 1'b0;
      while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
      exp8("mul_ff", cyc, 8, 8'h01, 8'hFE, 5'b00100);
      check("mul_idle", busy8, 1'b0);
      pulses = 0;
      repeat (4) begin @(negedge clk); if (done8) pulses++; end
      check("mul_one_done", pulses, 0);
      check("mul_hold", res8, 8'h01);

      // DIV
      run8(OP_DIV, 8'd200, 8'd7, cyc); exp8("div",    cyc, 8, 8'd28, 8'd4, 5'b00000);
      run8(OP_DIV, 8'd9,   8'd0, cyc); exp8("div_by0", cyc, 0, 8'hFF, 8'd9, 5'b00010);

      // Shifts, including amounts >= WIDTH and ignored high bits of b
      run8(OP_SHL, 8'h96, 8'd3,  cyc); exp8("shl3",  cyc, 0, 8'hB0, 8'h00, 5'b00000);
      run8(OP_SHR, 8'h96, 8'd3,  cyc); exp8("shr3",  cyc, 0, 8'h12, 8'h00, 5'b00000);
      run8(OP_SAR, 8'h96, 8'd3,  cyc); exp8("sar3",  cyc, 0, 8'hF2, 8'h00, 5'b00000);
      run8(OP_SHR, 8'h96, 8'd9,  cyc); exp8("shr9",  cyc, 0, 8'h00, 8'h00, 5'b10000);
      run8(OP_SAR, 8'h96, 8'd8,  cyc); exp8("sar8",  cyc, 0, 8'hFF, 8'h00, 5'b00000);
      run8(OP_SHL, 8'h96, 8'h13, cyc); exp8("shl_hi_ignored", cyc, 0, 8'hB0, 8'h00, 5'b00000);

      // Illegal opcode
      run8(6'b111111, 8'h55, 8'h33, cyc); exp8("illegal", cyc, 0, 8'h00, 8'h00, 5'b00001);

      // Back-to-back single-cycle starts on consecutive edges
      @(negedge clk);
      start8 = 1'b1; op8 = OP_ADD; a8 = 8'd1; b8 = 8'd2;
      @(negedge clk);
      check("b2b_first_done", done8, 1'b1);
      check("b2b_first_res",  res8, 8'd3);
      a8 = 8'd3; b8 = 8'd4;
      @(negedge clk);
      start8 = 1'b0;
      check("b2b_second_done", done8, 1'b1);
      check("b2b_second_res",  res8, 8'd7);

      // Reset in cycle 4 of a MUL abandons it
      @(negedge clk);
      start8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", busy8, 1'b0);
      check("mrst_done", done8, 1'b0);
      check("mrst_res",  {res8, hi8}, 16'h0000);
      check("mrst_flags", {zero8, carry8, ovf8, dbz8, ill8}, 5'b00000);
      pulses = 0;
      repeat (10) begin @(negedge clk); if (done8) pulses++; end
      check("mrst_no_done", pulses, 0);
      run8(OP_ADD, 8'd1, 8'd1, cyc); exp8("post_rst_add", cyc, 0, 8'd2, 8'h00, 5'b00000);

      // WIDTH=16 instance
      run16(OP_ADD, 16'hF000, 16'h2000, cyc); exp16("w16_add_carry", cyc, 0,  16'h1000, 16'h0000, 5'b01000);
      run16(OP_ADD, 16'h7FFF, 16'h0001, cyc); exp16("w16_add_ovf",   cyc, 0,  16'h8000, 16'h0000, 5'b00100);
      run16(OP_MUL, 16'hFFFF, 16'hFFFF, cyc); exp16("w16_mul",       cyc, 16, 16'h0001, 16'hFFFE, 5'b00100);
      run16(OP_DIV, 16'd50000, 16'd7,   cyc); exp16("w16_div",       cyc, 16, 16'd7142, 16'd6,    5'b00000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU of the microprocessor datapath.
- Generalised to WIDTH bits. Adds a start/busy/done handshake, iterative shift-add multiply and restoring divide with full-width outputs, status flags and illegal-opcode detection.
- Sits between the register file and writeback. The control unit issues one operation and waits for done.
- Opcode encoding is unchanged from the existing ALU, so microcode stays compatible.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH)+1, number of low bits of b used as the shift amount.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted on a rising clk edge when start=1 and busy=0
- op  in  6  opcode, sampled at acceptance
- a  in  WIDTH  operand A, sampled at acceptance
- b  in  WIDTH  operand B, sampled at acceptance
- result  out  WIDTH  primary result
- result_hi  out  WIDTH  MUL: upper product half; DIV: remainder; otherwise 0
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; result and flags valid
- zero  out  1  result==0 (result_hi not considered)
- carry  out  1  ADD: carry-out; SUB: borrow (a<b unsigned); otherwise 0
- overflow  out  1  signed overflow for ADD/SUB; MUL: result_hi≠0; otherwise 0
- div_by_zero  out  1  DIV with b==0
- illegal_op  out  1  op not in the table below

Behaviour:
- Reset: rst=1 at a clk edge clears all outputs and the state. State=IDLE, iteration counter=0. rst overrides start.
- Reset mid-operation abandons the operation with no done pulse.
- Opcodes, all unsigned except overflow:
  - 000000 ADD: a+b mod 2^WIDTH.
  - 000001 SUB: a-b mod 2^WIDTH.
  - 000010 MUL: full product; low half on result, high half on result_hi.
  - 000011 DIV: quotient on result, remainder on result_hi.
  - 000100 CMP: result[1:0]=01 if a>b, 10 if a<b, 00 if equal; upper bits 0.
  - 001000 NOT: ~a.
  - 001001 AND, 001010 OR, 001011 XOR: bitwise.
  - 010000 SHL: a << b[SHW-1:0]; zero fill.
  - 010001 SHR: logical a >> b[SHW-1:0]; zero fill.
  - 010010 SAR (new): arithmetic right shift by b[SHW-1:0]; sign fill.
- Shift amount ≥ WIDTH: SHL/SHR give 0; SAR gives all sign bits. Bits of b above SHW are ignored.
- Illegal opcode: result=0, result_hi=0, illegal_op=1, all other flags 0. Completes as a single-cycle op.
- States are IDLE, MUL, DIV.
- Single-cycle ops: accepted in IDLE at edge E0. Outputs register at E0 and done=1 for the cycle following E0. busy stays 0, so back-to-back starts on every cycle are accepted.
- MUL/DIV: at acceptance edge E0, operands are latched and the state moves to MUL or DIV. busy=1 from E0 until E_WIDTH. One iteration runs per cycle, WIDTH iterations in total.
- At E_WIDTH: outputs register, done=1 for one cycle, state returns to IDLE, busy=0. A start in the done cycle is accepted.
- start while busy=1 is ignored (dropped, not queued). op, a and b may change freely while busy.
- MUL uses shift-add over the multiplier bits, LSB first.
- DIV uses restoring division, MSB first, over a WIDTH+1-bit partial remainder.
- DIV with b==0: skips iteration, completing as a single-cycle op. result=all ones, result_hi=a, div_by_zero=1.
- Outputs hold their last values between done pulses. They change only at a completing edge or on reset.

Test Plan:
- Reset, then ADD a=8'hF0, b=8'h20 (WIDTH=8) -> next cycle done=1, result=8'h10, carry=1, zero=0, overflow=0. Then ADD 8'h7F+8'h01 -> result=8'h80, overflow=1.
- SUB a=5, b=7 -> result=8'hFE, carry=1. CMP 5 vs 7 -> result=8'h02. CMP 9 vs 9 -> result=0, zero=1.
- MUL a=8'hFF, b=8'hFF -> busy for 8 cycles, then done with result=8'h01, result_hi=8'hFE, overflow=1. A start pulse mid-operation is ignored: exactly one done pulse.
- DIV a=200, b=7 -> after 8 cycles result=28, result_hi=4. DIV a=9, b=0 -> next cycle done, result=8'hFF, result_hi=9, div_by_zero=1.
- Shifts with a=8'h96: SHL by 3 -> 8'hB0; SHR by 3 -> 8'h12; SAR by 3 -> 8'hF2; SHR by 9 -> 0; SAR by 8 -> 8'hFF. Opcode 6'b111111 -> illegal_op=1, result=0.
- Assert rst during cycle 4 of a MUL -> no done pulse, all outputs 0, busy=0. A following ADD 1+1 -> result=2. Repeat the ADD and MUL cases at WIDTH=16 for the parametrisation check.
